// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central hazard/stall controller for the 5-stage pipeline.
//             Resolves the hazards forwarding cannot: load-use stalls,
//             taken-branch flushes, structural stalls behind the multi-cycle
//             mult/div unit and data-memory wait freezes. Also sequences the
//             mult/div busy window.
//  Ports    :
//    clk, rst_n          clock (rising edge), async active-low reset
//    IFID_Rs/IFID_Rt     source registers of the instruction in ID
//    IDEX_Rt             destination of the load in EX
//    IDEX_MemRead        instruction in EX is a load
//    IFID_IsMD           instruction in ID is mult/multu/div/divu
//    IFID_UsesHiLo       instruction in ID is mfhi/mflo/mthi/mtlo
//    Branch_Taken        branch/jump in EX resolved taken
//    EXMEM_MemAccess     instruction in MEM accesses data memory
//    DMem_Ready          data memory completes this cycle
//    PC_Write/IFID_Write load enables for PC and IF/ID
//    IDEX_Bubble         insert nop into ID/EX
//    IFID_Flush/IDEX_Flush  clear IF/ID, ID/EX
//    Pipe_Freeze         hold ID/EX, EX/MEM, MEM/WB
//    MD_Start/MD_Busy    mult/div start pulse and busy indication
//    Mem_Error           sticky memory timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY  = 8,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic [4:0] IDEX_Rt,
    input  logic       IDEX_MemRead,
    input  logic       IFID_IsMD,
    input  logic       IFID_UsesHiLo,
    input  logic       Branch_Taken,
    input  logic       EXMEM_MemAccess,
    input  logic       DMem_Ready,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IDEX_Bubble,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       Pipe_Freeze,
    output logic       MD_Start,
    output logic       MD_Busy,
    output logic       Mem_Error
);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MD_BUSY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_md_reload  = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_mem_timeout = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic             r_mem_error;

    logic w_freeze;
    logic w_load_use;
    logic w_active;

    assign w_active   = (r_state == RUN) || (r_state == MD_BUSY);
    assign w_freeze   = w_active && EXMEM_MemAccess && !DMem_Ready;
    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign w_load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                        ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

    assign Mem_Error  = r_mem_error;

    // ------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_md_cnt    <= '0;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == c_mem_timeout) begin
                r_mem_error <= 1'b1;
            end
            // The mult/div unit runs on its own, so counting continues
            // through freezes and flushes.
            if (MD_Start) begin
                r_md_cnt <= c_md_reload;
            end else if ((r_state == MD_BUSY) && (r_md_cnt != '0)) begin
                r_md_cnt <= r_md_cnt - CNT_W'(1);
            end
        end
    end

    // Saturating memory-wait counter; any non-freeze cycle clears it.
    always_comb begin
        w_wait_nxt = '0;
        if (w_freeze) begin
            if (r_wait_cnt == c_mem_timeout) begin
                w_wait_nxt = r_wait_cnt;
            end else begin
                w_wait_nxt = r_wait_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and hazard outputs (priority: freeze, branch, load-use,
    // structural, mult/div issue)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        Pipe_Freeze = 1'b0;
        MD_Start    = 1'b0;
        MD_Busy     = 1'b0;

        case (r_state)
            INIT: begin
                PC_Write    = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
                w_state_nxt = RUN;
            end

            RUN, MD_BUSY: begin
                MD_Busy = (r_state == MD_BUSY);
                if (w_freeze) begin
                    Pipe_Freeze = 1'b1;
                    PC_Write    = 1'b0;
                    IFID_Write  = 1'b0;
                end else if (Branch_Taken) begin
                    // Everything younger than the branch is wrong-path, so
                    // no stall or issue decision is made for it.
                    IFID_Flush = 1'b1;
                    IDEX_Flush = 1'b1;
                end else if (w_load_use) begin
                    PC_Write    = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                end else if ((r_state == MD_BUSY) && (IFID_IsMD || IFID_UsesHiLo)) begin
                    PC_Write    = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                end else if ((r_state == RUN) && IFID_IsMD) begin
                    MD_Start    = 1'b1;
                    w_state_nxt = MD_BUSY;
                end

                if ((r_state == MD_BUSY) && (r_md_cnt == '0)) begin
                    w_state_nxt = RUN;
                end
            end

            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

endmodule
`default_nettype wire
